// File: rtl/ad_pn_pkg.sv
// ad_pn_pkg: PN polynomial constants, select encodings and checker states.
package ad_pn_pkg;
  typedef enum logic [2:0] {PN7 = 3'd0, PN9 = 3'd1, PN15 = 3'd2, PN23 = 3'd3, PN31 = 3'd4} pn_sel_e;
  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} chk_state_e;
  localparam int unsigned PN7_P = 7, PN7_T = 6;
  localparam int unsigned PN9_P = 9, PN9_T = 5;
  localparam int unsigned PN15_P = 15, PN15_T = 14;
  localparam int unsigned PN23_P = 23, PN23_T = 18;
  localparam int unsigned PN31_P = 31, PN31_T = 28;
  // taps as bit offsets into a state whose LSB is the newest bit; 5..7 fall back to PN7
  function automatic logic [4:0] tap_p(input logic [2:0] sel);
    return sel == PN9 ? 5'(PN9_P - 1) : sel == PN15 ? 5'(PN15_P - 1) :
           sel == PN23 ? 5'(PN23_P - 1) : sel == PN31 ? 5'(PN31_P - 1) : 5'(PN7_P - 1);
  endfunction
  function automatic logic [4:0] tap_t(input logic [2:0] sel);
    return sel == PN9 ? 5'(PN9_T - 1) : sel == PN15 ? 5'(PN15_T - 1) :
           sel == PN23 ? 5'(PN23_T - 1) : sel == PN31 ? 5'(PN31_T - 1) : 5'(PN7_T - 1);
  endfunction
endpackage

// File: rtl/ad_pn_step.sv
// ad_pn_step: extends a 31-bit PN history by DW bits (MSB of data is the oldest new bit).
module ad_pn_step
  import ad_pn_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [30:0]   state,
  input  logic [2:0]    pn_sel,
  output logic [DW-1:0] data,
  output logic [30:0]   next
);
  logic [4:0] p, t;
  assign p = tap_p(pn_sel);
  assign t = tap_t(pn_sel);
  always_comb begin
    next = state;
    data = '0;
    for (int i = 0; i < DW; i++) begin
      next = {next[29:0], next[p] ^ next[t]};
      data = {data[DW-2:0], next[0]};
    end
  end
endmodule

// File: rtl/ad_pn_mon_gen.sv
// ad_pn_mon_gen: PN7..PN31 pattern generator plus self-seeding lock/error monitor.
module ad_pn_mon_gen
  import ad_pn_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned OOS_CNT  = 8,
  parameter int unsigned ERR_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       pn_sel,
  input  logic             gen_en,
  output logic [DW-1:0]    gen_data,
  input  logic             chk_valid,
  input  logic [DW-1:0]    chk_data,
  input  logic             err_clr,
  output logic             pn_locked,
  output logic             pn_oos,
  output logic             pn_err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int unsigned H  = (31 + DW - 1) / DW;
  localparam int unsigned HW = H * DW;
  localparam int unsigned FW = $clog2(H + 1);
  function automatic int unsigned need(input logic [2:0] sel);
    return (32'(tap_p(sel)) + DW) / DW;
  endfunction
  logic [2:0]    sel_q;
  logic          sel_chg;
  logic [30:0]   gen_state, gen_cur, gen_next, chk_next_unused;
  logic [DW-1:0] gen_beat, exp_beat;
  logic [HW-1:0] hist;
  logic [FW-1:0] fill;
  logic [7:0]    match_cnt, miss_cnt;
  chk_state_e    st, st_n;
  logic          match, comparable, lock_hit, miss_hit, err_inc;
  assign sel_chg = pn_sel != sel_q;
  assign gen_cur = sel_chg ? '1 : gen_state;
  ad_pn_step #(.DW(DW)) u_gen (.state(gen_cur), .pn_sel(pn_sel), .data(gen_beat), .next(gen_next));
  ad_pn_step #(.DW(DW)) u_chk (.state(hist[30:0]), .pn_sel(pn_sel), .data(exp_beat), .next(chk_next_unused));
  assign match      = chk_data == exp_beat;
  assign comparable = 32'(fill) >= need(pn_sel);
  assign lock_hit   = comparable && match && 32'(match_cnt) == LOCK_CNT - 1;
  assign miss_hit   = !match && 32'(miss_cnt) == OOS_CNT - 1;
  assign err_inc    = !sel_chg && chk_valid && st == LOCKED && !match;
  assign st_n = sel_chg ? SEARCH : !chk_valid ? st :
                st == SEARCH ? (lock_hit ? LOCKED : SEARCH) : (miss_hit ? SEARCH : LOCKED);
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= pn_sel;
      gen_state <= '1;
      gen_data  <= '1;
    end else begin
      sel_q     <= pn_sel;
      gen_state <= gen_en ? gen_next : gen_cur;
      gen_data  <= gen_en ? gen_beat : gen_data;
    end
  end
  // SEARCH reseeds from received beats; LOCKED keeps extrapolating its own reference
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= SEARCH;
      pn_locked <= 1'b0;
      pn_oos    <= 1'b1;
      pn_err    <= 1'b0;
      err_cnt   <= '0;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      st        <= st_n;
      pn_locked <= st_n == LOCKED;
      pn_oos    <= st_n != LOCKED;
      pn_err    <= err_inc;
      err_cnt   <= err_clr ? ERR_W'(err_inc) : (err_inc && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
      if (sel_chg) begin
        fill      <= '0;
        match_cnt <= '0;
        miss_cnt  <= '0;
      end else if (chk_valid) begin
        if (st == SEARCH) begin
          hist      <= (hist << DW) | HW'(chk_data);
          fill      <= 32'(fill) == H ? fill : fill + 1'b1;
          match_cnt <= (comparable && match && !lock_hit) ? match_cnt + 1'b1 : '0;
        end else begin
          hist     <= (hist << DW) | HW'(exp_beat);
          fill     <= miss_hit ? '0 : fill;
          miss_cnt <= (match || miss_hit) ? '0 : miss_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/ad_pn_mon_gen.md
AD_PN_MON_GEN -- requirements
Module: ad_pn_mon_gen

Interface
REQ-001 Parameter DW, default 16: bits per beat, legal range 8..64; the MSB is the oldest bit and the LSB the newest.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive matching beats needed to declare lock, range 1..255.
REQ-003 Parameter OOS_CNT, default 8: number of consecutive mismatching beats, while locked, that declare loss of sync; range 1..255.
REQ-004 Parameter ERR_W, default 32: width of the error counter.
REQ-005 clk  in  1  clock; all logic is in this single domain.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 pn_sel  in  3  polynomial select: 0=PN7 (x^7+x^6+1), 1=PN9 (x^9+x^5+1), 2=PN15 (x^15+x^14+1), 3=PN23 (x^23+x^18+1), 4=PN31 (x^31+x^28+1); values 5..7 behave as PN7.
REQ-008 gen_en  in  1  advances the generator by one beat.
REQ-009 gen_data  out  DW  generator beat.
REQ-010 chk_valid  in  1  chk_data carries a beat this cycle.
REQ-011 chk_data  in  DW  received stream to check.
REQ-012 err_clr  in  1  clears err_cnt.
REQ-013 pn_locked  out  1  checker is in state LOCKED.
REQ-014 pn_oos  out  1  checker is out of sync, i.e. not LOCKED.
REQ-015 pn_err  out  1  one-cycle pulse flagging a mismatching beat while LOCKED.
REQ-016 err_cnt  out  ERR_W  count of mismatching beats seen while LOCKED; saturates at its maximum value.

Function
REQ-017 Sequence rule: b[n] = b[n-P] ^ b[n-T], where (P,T) = (7,6), (9,5), (15,14), (23,18) or (31,28).
REQ-018 Generator state is 31 bits wide and resets to all ones.
REQ-019 Generator output: each cycle with gen_en=1, the next DW sequence bits are emitted on gen_data, registered; latency is 1 cycle from gen_en.
REQ-020 gen_data holds its value while gen_en=0.
REQ-021 Checker history: H = ceil(31/DW) previous valid beats are held in a shift register.
REQ-022 Expected beat: the DW bits obtained by extrapolating the history with the selected polynomial.
REQ-023 History fill: a beat is "comparable" only once at least ceil(P/DW) beats have been accumulated since the last entry to SEARCH.
REQ-024 Checker FSM states: SEARCH (reset state) and LOCKED.
REQ-025 SEARCH: each comparable matching beat increments match_cnt; a mismatch, or a non-comparable beat, clears match_cnt; reaching match_cnt=LOCK_CNT moves the FSM to LOCKED.
REQ-026 SEARCH self-seeding: the history always loads the received beat, so the checker re-seeds from the incoming data.
REQ-027 LOCKED: a mismatching beat pulses pn_err on the next cycle, increments err_cnt and increments miss_cnt; a matching beat clears miss_cnt.
REQ-028 LOCKED: the history loads the expected beat rather than the received beat, so isolated errors do not corrupt the reference.
REQ-029 LOCKED: miss_cnt reaching OOS_CNT moves the FSM to SEARCH and clears the history-fill count.
REQ-030 Cycles with chk_valid=0 change no checker state.
REQ-031 A change of pn_sel between consecutive cycles forces the checker to SEARCH, clears match_cnt, miss_cnt and the fill count, and reloads the generator state to all ones.
REQ-032 err_clr=1 sets err_cnt to 0; if err_clr and an error increment occur in the same cycle, err_cnt becomes 1.
REQ-033 err_cnt holds at 2^ERR_W-1 once saturated; only err_clr or reset releases it.
REQ-034 pn_locked, pn_oos, pn_err and err_cnt are all registered outputs.

Reset
REQ-035 On reset: generator state all ones, gen_data all ones, history all zeros, FSM in SEARCH, all internal counters 0, pn_locked=0, pn_oos=1, pn_err=0, err_cnt=0.
REQ-036 Reset asserted mid-stream takes priority over every other input in that cycle.

Structure
REQ-037 Sub-module ad_pn_step: a combinational block that takes a 31-bit state and pn_sel and returns the next DW bits plus the next state; it is instantiated once for the generator and once for the checker.
REQ-038 The polynomial (P,T) constants and the pn_sel encodings are defined in a shared package, ad_pn_pkg.

Verification
REQ-039 Bench: DW=16, pn_sel=0, gen_data looped into chk_data with chk_valid=gen_en=1 -> pn_locked rises within H+LOCK_CNT+1 = 7 cycles; err_cnt stays 0 for 1000 beats.
REQ-040 Bench: locked, flip one bit of one beat -> exactly one pn_err pulse, err_cnt=1, pn_locked stays 1.
REQ-041 Bench: locked, force chk_data=0 for 8 beats -> pn_locked falls after the 8th beat, err_cnt=8; restore the stream -> relock.
REQ-042 Bench: sweep pn_sel 0..4 with DW=8 and DW=64 -> each setting locks and its generated sequence matches a software LFSR model.
REQ-043 Bench: change pn_sel while locked -> pn_locked=0 the next cycle and gen_data restarts from the all-ones seed.
REQ-044 Bench: ERR_W=4 with continuous errors -> err_cnt saturates at 15; err_clr together with an error -> err_cnt=1.
